// File: rtl/nor_reduce_sched.sv
// Round-robin scheduler sharing one SLICE-wide NOR/OR reducer among NREQ
// requesters; operands are reduced serially, one slice per cycle.
module nor_reduce_sched #(
    parameter int WIDTH      = 16,
    parameter int SLICE      = 4,
    parameter int NREQ       = 2,
    parameter int EARLY_EXIT = 0,
    localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       in_valid,
    input  logic [NREQ*WIDTH-1:0] in_data,
    output logic [NREQ-1:0]       in_ready,
    output logic                  out_valid,
    output logic                  out_nor,
    output logic [IW-1:0]         out_id,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int STEPS = WIDTH / SLICE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sreg;
    logic             acc;
    logic [CW-1:0]    count;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    winner;
    logic             any_req;
    logic             slice_or;
    logic             last;
    logic             nor_q;

    assign slice_or = |sreg[SLICE-1:0];
    assign last     = (count == CW'(STEPS - 1))
                   || ((EARLY_EXIT != 0) && (slice_or || acc));
    assign out_nor  = nor_q;

    // Pick the first valid requester at or after rr_ptr, wrapping around
    always_comb begin
        int idx;
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (in_valid[idx]) begin
                winner  = IW'(idx);
                any_req = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req)   state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = '0;
        if (state == IDLE && any_req) in_ready[winner] = 1'b1;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Operand capture, serial reduction and pointer advance
    always_ff @(posedge clk) begin
        if (!rst) begin
            sreg   <= '0;
            acc    <= 1'b0;
            count  <= '0;
            out_id <= '0;
            nor_q  <= 1'b0;
            rr_ptr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        sreg   <= in_data[int'(winner)*WIDTH +: WIDTH];
                        out_id <= winner;
                        acc    <= 1'b0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc | slice_or;
                    sreg  <= sreg >> SLICE;
                    count <= count + CW'(1);
                    if (last) nor_q <= ~(acc | slice_or);
                end
                DONE: begin
                    if (out_ready) begin
                        if (out_id == IW'(NREQ - 1)) rr_ptr <= '0;
                        else                         rr_ptr <= out_id + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nor_reduce_sched.sv
// Randomized bench for nor_reduce_sched: one instance without and one with
// early exit, each checked against a slice-level reference model.
module tb_nor_reduce_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  iv_a, iv_b;
    logic [31:0] d_a, d_b;
    logic        ordy_a, ordy_b;
    logic [1:0]  ir_a, ir_b;
    logic        ov_a, ov_b;
    logic        nor_a, nor_b;
    logic        id_a, id_b;
    logic        busy_a, busy_b;

    int passed = 0;
    int total  = 0;
    int ptr_a  = 0;

    always #5 clk = ~clk;

    nor_reduce_sched #(.WIDTH(16), .SLICE(4), .NREQ(2), .EARLY_EXIT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_data(d_a),
        .in_ready(ir_a), .out_valid(ov_a), .out_nor(nor_a), .out_id(id_a),
        .out_ready(ordy_a), .busy(busy_a)
    );

    nor_reduce_sched #(.WIDTH(16), .SLICE(4), .NREQ(2), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_data(d_b),
        .in_ready(ir_b), .out_valid(ov_b), .out_nor(nor_b), .out_id(id_b),
        .out_ready(ordy_b), .busy(busy_b)
    );

    // Reference: cycles from acceptance to out_valid
    function automatic int exp_lat(bit ee, logic [15:0] d);
        if (!ee) return 4;
        for (int k = 0; k < 4; k++)
            if (d[k*4 +: 4] != 4'h0) return k + 1;
        return 4;
    endfunction

    function automatic logic [15:0] rnd_data();
        logic [31:0] r;
        r = 32'($urandom & 32'hFFFF) << (4 * $urandom_range(0, 4));
        return r[15:0];
    endfunction

    // Run one single-requester job to completion with out_ready held high
    task automatic do_job(input bit ee, input int req, input logic [15:0] data,
                          output logic [1:0] rdy, output int lat,
                          output logic nor_o, output logic id_o);
        logic [31:0] d;
        d = $urandom;
        d[req*16 +: 16] = data;
        if (ee) begin
            iv_b = 2'b01 << req; d_b = d; ordy_b = 1'b1;
        end else begin
            iv_a = 2'b01 << req; d_a = d; ordy_a = 1'b1;
        end
        #1;
        rdy = ee ? ir_b : ir_a;
        @(posedge clk); #1;
        iv_a = 2'b00; iv_b = 2'b00;
        lat = 0;
        while (!(ee ? ov_b : ov_a) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        nor_o = ee ? nor_b : nor_a;
        id_o  = ee ? id_b : id_a;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        iv_a = 0; iv_b = 0; d_a = 0; d_b = 0; ordy_a = 0; ordy_b = 0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        total++;
        if ({ir_a, ov_a, nor_a, id_a, busy_a} !== 6'b0) begin
            $display("FAIL reset_a got=%b exp=000000",
                     {ir_a, ov_a, nor_a, id_a, busy_a});
        end else passed++;
        total++;
        if ({ir_b, ov_b, nor_b, id_b, busy_b} !== 6'b0) begin
            $display("FAIL reset_b got=%b exp=000000",
                     {ir_b, ov_b, nor_b, id_b, busy_b});
        end else passed++;
        ptr_a = 0;
    endtask

    task automatic test_basic();
        logic [15:0] pat [3];
        logic [1:0]  rdy;
        int          lat;
        logic        nr, id;
        pat[0] = 16'h0000; pat[1] = 16'h0100; pat[2] = 16'h8000;
        for (int i = 0; i < 3; i++) begin
            do_job(1'b0, 0, pat[i], rdy, lat, nr, id);
            ptr_a = 1;
            total++;
            if (rdy !== 2'b01) begin
                $display("FAIL basic_ready[%0d] got=%b exp=01", i, rdy);
            end else passed++;
            total++;
            if (lat != 4) begin
                $display("FAIL basic_lat[%0d] got=%0d exp=4", i, lat);
            end else passed++;
            total++;
            if ({nr, id} !== {(pat[i] == 16'h0), 1'b0}) begin
                $display("FAIL basic_result[%0d] got=%b%b exp=%b0",
                         i, nr, id, (pat[i] == 16'h0));
            end else passed++;
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [1:0]  rdy;
        int          req, lat;
        logic        nr, id;
        for (int i = 0; i < 10; i++) begin
            req = $urandom_range(0, 1);
            d   = rnd_data();
            do_job(1'b0, req, d, rdy, lat, nr, id);
            ptr_a = (req + 1) % 2;
            total++;
            if (rdy !== (2'b01 << req)) begin
                $display("FAIL rand_ready[%0d] got=%b req=%0d", i, rdy, req);
            end else passed++;
            total++;
            if (lat != exp_lat(1'b0, d)) begin
                $display("FAIL rand_lat[%0d] got=%0d exp=%0d",
                         i, lat, exp_lat(1'b0, d));
            end else passed++;
            total++;
            if (nr !== (d == 16'h0) || id !== req[0]) begin
                $display("FAIL rand_result[%0d] d=%h got nor=%b id=%b exp nor=%b id=%0d",
                         i, d, nr, id, (d == 16'h0), req);
            end else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] dd [2];
        int exp_id, idle_n, nres;
        dd[0] = 16'h0000;
        dd[1] = 16'($urandom) | 16'h0001;
        d_a = {dd[1], dd[0]};
        iv_a = 2'b11; ordy_a = 1'b1;
        exp_id = ptr_a; idle_n = 0; nres = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            total++;
            if (ir_a === 2'b11) begin
                $display("FAIL b2b_onehot cyc=%0d got=%b", c, ir_a);
            end else passed++;
            if (!busy_a) idle_n++;
            if (ov_a) begin
                total++;
                if (id_a !== exp_id[0] || nor_a !== (dd[exp_id] == 16'h0)) begin
                    $display("FAIL b2b_result n=%0d got id=%b nor=%b exp id=%0d nor=%b",
                             nres, id_a, nor_a, exp_id, (dd[exp_id] == 16'h0));
                end else passed++;
                if (nres > 0) begin
                    total++;
                    if (idle_n != 1) begin
                        $display("FAIL b2b_idle n=%0d got=%0d exp=1", nres, idle_n);
                    end else passed++;
                end
                idle_n = 0;
                nres++;
                exp_id = (exp_id + 1) % 2;
                ptr_a = exp_id;
            end
        end
        total++;
        if (nres < 5) begin
            $display("FAIL b2b_count got=%0d exp>=5", nres);
        end else passed++;
        iv_a = 2'b00;
        for (int c = 0; c < 20 && busy_a; c++) begin
            if (ov_a) ptr_a = (int'(id_a) + 1) % 2;
            @(posedge clk); #1;
        end
        total++;
        if (busy_a !== 1'b0) begin
            $display("FAIL b2b_drain got busy=%b exp=0", busy_a);
        end else passed++;
    endtask

    task automatic test_stall();
        logic [15:0] dd [2];
        logic        nr0, id0;
        int          w, c;
        dd[0] = rnd_data(); dd[1] = rnd_data();
        d_a = {dd[1], dd[0]};
        iv_a = 2'b11; ordy_a = 1'b0;
        w = ptr_a;
        c = 0;
        while (!ov_a && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        nr0 = nor_a; id0 = id_a;
        total++;
        if (!ov_a || id0 !== w[0] || nr0 !== (dd[w] == 16'h0)) begin
            $display("FAIL stall_result got ov=%b id=%b nor=%b exp ov=1 id=%0d nor=%b",
                     ov_a, id0, nr0, w, (dd[w] == 16'h0));
        end else passed++;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            total++;
            if ({ov_a, nor_a, id_a, ir_a, busy_a} !== {1'b1, nr0, id0, 2'b00, 1'b1}) begin
                $display("FAIL stall_hold[%0d] got=%b exp=%b", k,
                         {ov_a, nor_a, id_a, ir_a, busy_a},
                         {1'b1, nr0, id0, 2'b00, 1'b1});
            end else passed++;
        end
        ordy_a = 1'b1;
        @(posedge clk); #1;
        ptr_a = (w + 1) % 2;
        total++;
        if (ov_a !== 1'b0) begin
            $display("FAIL stall_release got ov=%b exp=0", ov_a);
        end else passed++;
        total++;
        if (ir_a !== (2'b01 << ptr_a)) begin
            $display("FAIL stall_regrant got=%b exp=%b", ir_a, 2'b01 << ptr_a);
        end else passed++;
        iv_a = 2'b00;
    endtask

    task automatic test_reset_mid();
        logic [1:0] rdy;
        int         lat;
        logic       nr, id;
        do_job(1'b0, 0, rnd_data(), rdy, lat, nr, id);
        ptr_a = 1;
        iv_a = 2'b01; d_a = 32'h0000_0100; ordy_a = 1'b1;
        @(posedge clk); #1;
        iv_a = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        ptr_a = 0;
        total++;
        if ({ov_a, nor_a, id_a, busy_a, ir_a} !== 6'b0) begin
            $display("FAIL midrst_outputs got=%b exp=000000",
                     {ov_a, nor_a, id_a, busy_a, ir_a});
        end else passed++;
        iv_a = 2'b11;
        #1;
        total++;
        if (ir_a !== 2'b01) begin
            $display("FAIL midrst_ptr got=%b exp=01", ir_a);
        end else passed++;
        iv_a = 2'b00;
        @(posedge clk); #1;
        do_job(1'b0, 1, 16'h0000, rdy, lat, nr, id);
        ptr_a = 0;
        total++;
        if (lat != 4 || nr !== 1'b1 || id !== 1'b1) begin
            $display("FAIL midrst_job got lat=%0d nor=%b id=%b exp lat=4 nor=1 id=1",
                     lat, nr, id);
        end else passed++;
    endtask

    task automatic test_early_exit();
        logic [15:0] d;
        logic [1:0]  rdy;
        int          req, lat;
        logic        nr, id;
        for (int i = 0; i < 10; i++) begin
            req = (i < 2) ? 0 : $urandom_range(0, 1);
            d   = (i == 0) ? 16'h0001 : (i == 1) ? 16'h0000 : rnd_data();
            do_job(1'b1, req, d, rdy, lat, nr, id);
            total++;
            if (lat != exp_lat(1'b1, d)) begin
                $display("FAIL ee_lat[%0d] d=%h got=%0d exp=%0d",
                         i, d, lat, exp_lat(1'b1, d));
            end else passed++;
            total++;
            if (nr !== (d == 16'h0) || id !== req[0] || rdy !== (2'b01 << req)) begin
                $display("FAIL ee_result[%0d] d=%h got nor=%b id=%b rdy=%b exp nor=%b id=%0d",
                         i, d, nr, id, rdy, (d == 16'h0), req);
            end else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_early_exit();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
